frame_seq_ctrl: RTL

Frame sequencer for the RF receive path. Consumes the per-bit strobe and value produced by the RF pulse sampler, hunts for the 8-one preamble, skips the 27-bit field, checks the 8-one sync field and drives `sh_en` to clock exactly 32 payload bits into the shift buffer. It then holds the frame until the transmitter is ready, issues a one-cycle `fsm_rst` to re-arm the sampler/buffer, and returns to hunting.

---
 rtl/frame_seq_pkg.sv | 25 ++
 rtl/fseq_watchdog.sv | 37 +++
 rtl/frame_seq_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/frame_seq_pkg.sv
// Shared types and default lengths for the RF frame sequencer.
// The watchdog width and default limit apply only when FRAME_SEQ_TIMEOUT_EN is defined.
package frame_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HUNT  = 3'd1,
    GAP   = 3'd2,
    SYNC  = 3'd3,
    LOAD  = 3'd4,
    HOLD  = 3'd5,
    REARM = 3'd6
  } fseq_state_t;

  localparam int FSEQ_CNT_W   = 6;
  localparam int FSEQ_MAX_LEN = 63;
  localparam int FSEQ_WD_W    = 14;

  localparam int PRE_LEN_DEF  = 8;
  localparam int GAP_LEN_DEF  = 27;
  localparam int SYNC_LEN_DEF = 8;
  localparam int PAY_LEN_DEF  = 32;
  localparam int TO_CYC_DEF   = 15000;

endpackage

// File: rtl/fseq_watchdog.sv
// Inter-strobe watchdog for the frame sequencer; instantiated only when
// FRAME_SEQ_TIMEOUT_EN is defined.
module fseq_watchdog
  import frame_seq_pkg::*;
#(
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic timeout
);

  localparam logic [FSEQ_WD_W-1:0] TO_LAST = FSEQ_WD_W'(TO_CYC - 1);
  localparam logic [FSEQ_WD_W-1:0] WD_ZERO = 14'd0;
  localparam logic [FSEQ_WD_W-1:0] WD_ONE  = 14'd1;

  logic [FSEQ_WD_W-1:0] cnt_r;

  // Clock counter since the last strobe while a frame is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= WD_ZERO;
    end else if (!en || clr) begin
      cnt_r <= WD_ZERO;
    end else if (cnt_r != TO_LAST) begin
      cnt_r <= cnt_r + WD_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Reaching TO_LAST means the next edge is TO_CYC clocks after the strobe
  assign timeout = en && (cnt_r == TO_LAST);

endmodule

// File: rtl/frame_seq_ctrl.sv
// Frame sequencer: preamble hunt, gap skip, sync check, payload shift, hold/handoff.
// Optional inter-strobe watchdog enabled by defining FRAME_SEQ_TIMEOUT_EN.
module frame_seq_ctrl
  import frame_seq_pkg::*;
#(
  parameter int PRE_LEN  = PRE_LEN_DEF,
  parameter int GAP_LEN  = GAP_LEN_DEF,
  parameter int SYNC_LEN = SYNC_LEN_DEF,
  parameter int PAY_LEN  = PAY_LEN_DEF,
  parameter int TO_CYC   = TO_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_stb,
  input  logic                  bit_val,
  input  logic                  RX,
  input  logic                  tx_rdy,
  output logic                  sh_en,
  output logic                  sh_din,
  output logic                  frame_rdy,
  output logic                  tx_start,
  output logic                  fsm_rst,
  output logic [FSEQ_CNT_W-1:0] bit_cnt
);

  if (PRE_LEN < 1 || PRE_LEN > FSEQ_MAX_LEN || GAP_LEN < 1 || GAP_LEN > FSEQ_MAX_LEN ||
      SYNC_LEN < 1 || SYNC_LEN > FSEQ_MAX_LEN || PAY_LEN < 1 || PAY_LEN > FSEQ_MAX_LEN ||
      TO_CYC < 2 || TO_CYC > (1 << FSEQ_WD_W)) begin : g_len_chk
    $error("frame_seq_ctrl: length parameters out of range");
  end

  localparam logic [FSEQ_CNT_W-1:0] CNT_ZERO  = 6'd0;
  localparam logic [FSEQ_CNT_W-1:0] CNT_ONE   = 6'd1;
  localparam logic [FSEQ_CNT_W-1:0] PRE_LAST  = FSEQ_CNT_W'(PRE_LEN - 1);
  localparam logic [FSEQ_CNT_W-1:0] GAP_LAST  = FSEQ_CNT_W'(GAP_LEN - 1);
  localparam logic [FSEQ_CNT_W-1:0] SYNC_LAST = FSEQ_CNT_W'(SYNC_LEN - 1);
  localparam logic [FSEQ_CNT_W-1:0] PAY_LAST  = FSEQ_CNT_W'(PAY_LEN - 1);

  fseq_state_t           state_r, state_s;
  logic [FSEQ_CNT_W-1:0] cnt_r, cnt_s;
  logic                  sh_en_r, sh_en_s;
  logic                  sh_din_r, sh_din_s;
  logic                  frame_rdy_r, frame_rdy_s;
  logic                  tx_start_r, tx_start_s;
  logic                  fsm_rst_r, fsm_rst_s;
  logic                  wd_timeout_s;

`ifdef FRAME_SEQ_TIMEOUT_EN
  logic wd_en_s;
  assign wd_en_s = (state_r == GAP) || (state_r == SYNC) || (state_r == LOAD);

  fseq_watchdog #(.TO_CYC(TO_CYC)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst),
    .en      (wd_en_s),
    .clr     (bit_stb),
    .timeout (wd_timeout_s)
  );
`else
  assign wd_timeout_s = 1'b0;
`endif

  // Next-state, counter and output decode; RX abort beats watchdog beats strobe
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    sh_en_s    = 1'b0;
    sh_din_s   = 1'b0;
    tx_start_s = 1'b0;
    fsm_rst_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        if (RX) begin
          state_s = HUNT;
        end else begin
          state_s = IDLE;
        end
      end
      HUNT, GAP, SYNC, LOAD: begin
        if (!RX) begin
          state_s   = IDLE;
          cnt_s     = CNT_ZERO;
          fsm_rst_s = 1'b1;
        end else if (wd_timeout_s) begin
          state_s   = HUNT;
          cnt_s     = CNT_ZERO;
          fsm_rst_s = 1'b1;
        end else if (bit_stb) begin
          case (state_r)
            HUNT: begin
              if (!bit_val) begin
                cnt_s = CNT_ZERO;
              end else if (cnt_r == PRE_LAST) begin
                state_s = GAP;
                cnt_s   = CNT_ZERO;
              end else begin
                cnt_s = cnt_r + CNT_ONE;
              end
            end
            GAP: begin
              if (cnt_r == GAP_LAST) begin
                state_s = SYNC;
                cnt_s   = CNT_ZERO;
              end else begin
                cnt_s = cnt_r + CNT_ONE;
              end
            end
            SYNC: begin
              if (!bit_val) begin
                state_s = HUNT;
                cnt_s   = CNT_ZERO;
              end else if (cnt_r == SYNC_LAST) begin
                state_s = LOAD;
                cnt_s   = CNT_ZERO;
              end else begin
                cnt_s = cnt_r + CNT_ONE;
              end
            end
            LOAD: begin
              sh_en_s  = 1'b1;
              sh_din_s = bit_val;
              if (cnt_r == PAY_LAST) begin
                state_s = HOLD;
                cnt_s   = CNT_ZERO;
              end else begin
                cnt_s = cnt_r + CNT_ONE;
              end
            end
            default: begin
              state_s = IDLE;
              cnt_s   = CNT_ZERO;
            end
          endcase
        end else begin
          state_s = state_r;
        end
      end
      HOLD: begin
        if (!RX && tx_rdy) begin
          state_s    = REARM;
          tx_start_s = 1'b1;
        end else begin
          state_s = HOLD;
        end
      end
      REARM: begin
        state_s   = IDLE;
        fsm_rst_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
    // frame_rdy stays up through the handoff and drops with the re-arm pulse
    frame_rdy_s = (state_s == HOLD) || (state_s == REARM);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      sh_en_r     <= 1'b0;
      sh_din_r    <= 1'b0;
      frame_rdy_r <= 1'b0;
      tx_start_r  <= 1'b0;
      fsm_rst_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      sh_en_r     <= sh_en_s;
      sh_din_r    <= sh_din_s;
      frame_rdy_r <= frame_rdy_s;
      tx_start_r  <= tx_start_s;
      fsm_rst_r   <= fsm_rst_s;
    end
  end

  assign sh_en     = sh_en_r;
  assign sh_din    = sh_din_r;
  assign frame_rdy = frame_rdy_r;
  assign tx_start  = tx_start_r;
  assign fsm_rst   = fsm_rst_r;
  assign bit_cnt   = cnt_r;

endmodule
